// File: rtl/mem_req_pattern_checker_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_pattern_checker_pkg
// Shared types and constants for the memory request pattern checker.
//   ADDR_W / TX_SIZE_W / RD_LOOP_W : field widths of a table entry. They live
//                                    here because chk_entry_t is a packed struct.
//   chk_entry_t  : one table entry {last, base, stride, size, loop_max}
//   chk_state_e  : channel FSM state
//   err_code_e   : error record codes (ERR_ADDR/ERR_SIZE/ERR_OVERRUN/ERR_TIMEOUT)
//   ch_w()       : width of a channel index (at least 1 bit)
// -----------------------------------------------------------------------------
package mem_req_pattern_checker_pkg;

  localparam int ADDR_W    = 32;
  localparam int TX_SIZE_W = 20;
  localparam int RD_LOOP_W = 10;

  typedef struct packed {
    logic                 last;
    logic [ADDR_W-1:0]    base;
    logic [ADDR_W-1:0]    stride;
    logic [TX_SIZE_W-1:0] size;
    logic [RD_LOOP_W-1:0] loop_max;
  } chk_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  typedef enum logic [1:0] {
    ERR_ADDR    = 2'd0,
    ERR_SIZE    = 2'd1,
    ERR_OVERRUN = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_pattern_checker_if.sv
// -----------------------------------------------------------------------------
// mem_req_pattern_checker_if
// Request bus observed by the checker, one lane per channel.
//   req_valid : per-channel request strobe
//   req_addr  : per-channel request address, channel i in [i*ADDR_W +: ADDR_W]
//   req_size  : per-channel request size, channel i in [i*TX_SIZE_W +: TX_SIZE_W]
// Modports: master (request source), slave (checker side).
// -----------------------------------------------------------------------------
interface mem_req_pattern_checker_if #(
  parameter int NUM_CH = 2
);
  import mem_req_pattern_checker_pkg::*;

  logic [NUM_CH-1:0]           req_valid;
  logic [NUM_CH*ADDR_W-1:0]    req_addr;
  logic [NUM_CH*TX_SIZE_W-1:0] req_size;

  modport master (output req_valid, output req_addr, output req_size);
  modport slave  (input  req_valid, input  req_addr, input  req_size);

endinterface

// File: rtl/mem_req_chk_channel.sv
// -----------------------------------------------------------------------------
// mem_req_chk_channel
// One checker channel: pattern table, IDLE/RUN/DONE FSM, loop/offset/stall
// counters and the request comparator. Error outputs are combinational for the
// current cycle; the top level registers and arbitrates them.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 arm the channel at table entry 0 (restarts if running)
//   cfg_we/cfg_idx/cfg_data  table write port (gating done by the top level)
//   timeout_max           stall limit in cycles, 0 disables
//   req_valid/addr/size   observed request
//   busy, done            state == RUN / state == DONE
//   err_hit, err_code, err_exp, err_got  error detected this cycle
// Build option: PATTERN_CHK_SIZE_EN enables the request size comparison.
// -----------------------------------------------------------------------------
module mem_req_chk_channel
  import mem_req_pattern_checker_pkg::*;
#(
  parameter int TBL_ADDR_W = 6,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [TBL_ADDR_W-1:0] cfg_idx,
  input  chk_entry_t            cfg_data,
  input  logic [TIMEOUT_W-1:0]  timeout_max,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [TX_SIZE_W-1:0]  req_size,
  output logic                  busy,
  output logic                  done,
  output logic                  err_hit,
  output err_code_e             err_code,
  output logic [ADDR_W-1:0]     err_exp,
  output logic [ADDR_W-1:0]     err_got
);

  // Pattern table. Read asynchronously on the current index so the expected
  // address is available in the same cycle as the request.
  chk_entry_t tbl_mem [2**TBL_ADDR_W];

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_mem[cfg_idx] <= cfg_data;
    end
  end

  chk_state_e            state_reg, state_next;
  logic [TBL_ADDR_W-1:0] idx_reg,   idx_next;
  logic [RD_LOOP_W-1:0]  cnt_reg,   cnt_next;
  logic [ADDR_W-1:0]     off_reg,   off_next;
  logic [TIMEOUT_W-1:0]  stall_reg, stall_next;

  chk_entry_t          entry;
  logic [ADDR_W-1:0]   exp_addr;
  logic                entry_end;
  logic                last_entry;
  logic [TIMEOUT_W:0]  stall_inc;
  logic                stall_hit;
  logic                addr_mis;
  logic                size_mis;

  assign entry      = tbl_mem[idx_reg];
  assign exp_addr   = entry.base + off_reg;
  assign entry_end  = (cnt_reg == entry.loop_max);
  // The final table slot terminates the pattern even without its last flag.
  assign last_entry = entry.last | (&idx_reg);
  // One extra bit so the compare stays correct if timeout_max is lowered
  // below an already accumulated count.
  assign stall_inc  = {1'b0, stall_reg} + (TIMEOUT_W+1)'(1);
  assign stall_hit  = (timeout_max != '0) && (stall_inc >= {1'b0, timeout_max});
  assign addr_mis   = (req_addr != exp_addr);

`ifdef PATTERN_CHK_SIZE_EN
  assign size_mis = (req_size != entry.size);
`else
  logic unused_size;
  assign size_mis    = 1'b0;
  assign unused_size = ^{req_size, entry.size};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      off_reg   <= '0;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      off_reg   <= off_next;
      stall_reg <= stall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    off_next   = off_reg;
    stall_next = stall_reg;
    err_hit    = 1'b0;
    err_code   = ERR_ADDR;
    err_exp    = exp_addr;
    err_got    = req_addr;

    if (start) begin
      // Restart wins over anything observed in the same cycle.
      state_next = ST_RUN;
      idx_next   = '0;
      cnt_next   = '0;
      off_next   = '0;
      stall_next = '0;
    end else begin
      unique case (state_reg)
        ST_RUN: begin
          if (req_valid) begin
            stall_next = '0;
            // Address mismatch takes precedence so a double mismatch is one error.
            if (addr_mis) begin
              err_hit  = 1'b1;
              err_code = ERR_ADDR;
            end else if (size_mis) begin
              err_hit  = 1'b1;
              err_code = ERR_SIZE;
            end
            // Always advance; there is no resynchronisation on mismatch.
            if (entry_end) begin
              cnt_next = '0;
              off_next = '0;
              if (last_entry) begin
                state_next = ST_DONE;
              end else begin
                idx_next = idx_reg + TBL_ADDR_W'(1);
              end
            end else begin
              cnt_next = cnt_reg + RD_LOOP_W'(1);
              off_next = off_reg + entry.stride;
            end
          end else if (stall_hit) begin
            err_hit    = 1'b1;
            err_code   = ERR_TIMEOUT;
            err_got    = '0;
            state_next = ST_DONE;
          end else begin
            stall_next = stall_inc[TIMEOUT_W-1:0];
          end
        end
        ST_DONE: begin
          if (req_valid) begin
            err_hit  = 1'b1;
            err_code = ERR_OVERRUN;
            err_exp  = '0;
          end
        end
        default: begin
          // IDLE: requests are not checked.
        end
      endcase
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

endmodule

// File: rtl/mem_req_pattern_checker.sv
// -----------------------------------------------------------------------------
// mem_req_pattern_checker (top)
// Multi-channel checker for accelerator memory read requests. Each channel
// walks its own table of {last, base, stride, size, loop_max} entries and
// compares every observed request with the expected address (and size).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             pulse: arm all channels from entry 0, clear pass/fail/err_count
//   cfg_we/cfg_ch/cfg_idx/cfg_data  table write, ignored while busy
//   timeout_max       stall limit in cycles, 0 disables
//   req               request bus (mem_req_pattern_checker_if.slave)
//   busy              any channel in RUN
//   done              1-cycle pulse once all channels are DONE
//   pass / fail       sticky verdict, evaluated the cycle after all channels are DONE
//   err_valid/err_ch/err_code/err_exp/err_got  registered error record
//   err_count         saturating count of errors since start
// Build option: PATTERN_CHK_SIZE_EN enables size checking (error code 1).
// -----------------------------------------------------------------------------
module mem_req_pattern_checker
  import mem_req_pattern_checker_pkg::*;
#(
  parameter  int NUM_CH     = 2,
  parameter  int TBL_ADDR_W = 6,
  parameter  int ERR_CNT_W  = 16,
  parameter  int TIMEOUT_W  = 20,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        cfg_we,
  input  logic [CH_W-1:0]             cfg_ch,
  input  logic [TBL_ADDR_W-1:0]       cfg_idx,
  input  chk_entry_t                  cfg_data,
  input  logic [TIMEOUT_W-1:0]        timeout_max,
  mem_req_pattern_checker_if.slave    req,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic                        err_valid,
  output logic [CH_W-1:0]             err_ch,
  output logic [1:0]                  err_code,
  output logic [ADDR_W-1:0]           err_exp,
  output logic [ADDR_W-1:0]           err_got,
  output logic [ERR_CNT_W-1:0]        err_count
);

  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_err;
  err_code_e         ch_code [NUM_CH];
  logic [ADDR_W-1:0] ch_exp  [NUM_CH];
  logic [ADDR_W-1:0] ch_got  [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic ch_we;
      assign ch_we = cfg_we & ~busy & (cfg_ch == CH_W'(gi));

      mem_req_chk_channel #(
        .TBL_ADDR_W (TBL_ADDR_W),
        .TIMEOUT_W  (TIMEOUT_W)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_we      (ch_we),
        .cfg_idx     (cfg_idx),
        .cfg_data    (cfg_data),
        .timeout_max (timeout_max),
        .req_valid   (req.req_valid[gi]),
        .req_addr    (req.req_addr[gi*ADDR_W +: ADDR_W]),
        .req_size    (req.req_size[gi*TX_SIZE_W +: TX_SIZE_W]),
        .busy        (ch_busy[gi]),
        .done        (ch_done[gi]),
        .err_hit     (ch_err[gi]),
        .err_code    (ch_code[gi]),
        .err_exp     (ch_exp[gi]),
        .err_got     (ch_got[gi])
      );
    end
  endgenerate

  assign busy = |ch_busy;

  // Lowest-numbered erroring channel owns the record; all are counted.
  logic [CH_W-1:0]    sel_ch;
  err_code_e          sel_code;
  logic [ADDR_W-1:0]  sel_exp;
  logic [ADDR_W-1:0]  sel_got;
  logic [ERR_CNT_W:0] pop_cnt;
  logic [ERR_CNT_W:0] cnt_sum;
  logic [ERR_CNT_W-1:0] cnt_sat;

  always_comb begin
    sel_ch   = '0;
    sel_code = ERR_ADDR;
    sel_exp  = '0;
    sel_got  = '0;
    pop_cnt  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_err[i]) begin
        sel_ch   = CH_W'(i);
        sel_code = ch_code[i];
        sel_exp  = ch_exp[i];
        sel_got  = ch_got[i];
        pop_cnt  = pop_cnt + (ERR_CNT_W+1)'(1);
      end
    end
    cnt_sum = {1'b0, err_count} + pop_cnt;
    cnt_sat = cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
  end

  logic all_done;
  logic judged_reg;

  assign all_done = &ch_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_ch     <= '0;
      err_code   <= '0;
      err_exp    <= '0;
      err_got    <= '0;
      err_count  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      judged_reg <= 1'b0;
    end else begin
      err_valid <= |ch_err;
      if (|ch_err) begin
        err_ch   <= sel_ch;
        err_code <= sel_code;
        err_exp  <= sel_exp;
        err_got  <= sel_got;
      end
      done <= 1'b0;
      if (start) begin
        err_count  <= '0;
        pass       <= 1'b0;
        fail       <= 1'b0;
        judged_reg <= 1'b0;
      end else begin
        err_count <= cnt_sat;
        // err_count already includes errors raised on the edge that moved the
        // last channel into DONE, so the verdict is taken one cycle later.
        if (all_done && !judged_reg) begin
          judged_reg <= 1'b1;
          done       <= 1'b1;
          pass       <= (err_count == '0);
          fail       <= (err_count != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_mem_req_pattern_checker
// Directed-vector bench for mem_req_pattern_checker. Channel 0 holds a single
// looping entry, channel 1 two entries so entry advance is exercised.
//   ch0: {last, base 0x1000, stride 0x40, size 32, loop_max 3} -> 1000 1040 1080 10C0
//   ch1: {base 0x2000, stride 0x10, loop_max 1}, {last, base 0x3000, stride 0x8,
//        loop_max 1} -> 2000 2010 3000 3008
// Honours PATTERN_CHK_SIZE_EN like the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_req_pattern_checker;
  import mem_req_pattern_checker_pkg::*;

`ifdef PATTERN_CHK_SIZE_EN
  localparam bit SIZE_CHK = 1'b1;
`else
  localparam bit SIZE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [5:0]  cfg_idx;
  chk_entry_t  cfg_data;
  logic [19:0] timeout_max;
  logic        busy, done, pass, fail, err_valid;
  logic [0:0]  err_ch;
  logic [1:0]  err_code;
  logic [31:0] err_exp, err_got;
  logic [15:0] err_count;

  int n_vec  = 0;
  int n_miss = 0;

  mem_req_pattern_checker_if #(.NUM_CH(2)) req_bus ();

  mem_req_pattern_checker #(
    .NUM_CH(2), .TBL_ADDR_W(6), .ERR_CNT_W(16), .TIMEOUT_W(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .timeout_max (timeout_max),
    .req         (req_bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .err_valid   (err_valid),
    .err_ch      (err_ch),
    .err_code    (err_code),
    .err_exp     (err_exp),
    .err_got     (err_got),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cfg_write(input logic ch, input logic [5:0] idx, input logic last,
                           input logic [31:0] base, input logic [31:0] stride,
                           input logic [19:0] size, input logic [9:0] lmax);
    cfg_ch            = ch;
    cfg_idx           = idx;
    cfg_data.last     = last;
    cfg_data.base     = base;
    cfg_data.stride   = stride;
    cfg_data.size     = size;
    cfg_data.loop_max = lmax;
    cfg_we            = 1'b1;
    tick();
    cfg_we            = 1'b0;
  endtask

  task automatic drive_req(input logic v0, input logic [31:0] a0,
                           input logic v1, input logic [31:0] a1);
    req_bus.req_valid = {v1, v0};
    req_bus.req_addr  = {a1, a0};
    tick();
    req_bus.req_valid = 2'b00;
    $display("req ch0 v=%0b a=%h ch1 v=%0b a=%h -> err_valid=%0b ch=%0d code=%0d cnt=%0d",
             v0, a0, v1, a1, err_valid, err_ch, err_code, err_count);
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    cfg_we            = 1'b0;
    cfg_ch            = '0;
    cfg_idx           = '0;
    cfg_data          = '0;
    timeout_max       = '0;
    req_bus.req_valid = '0;
    req_bus.req_addr  = '0;
    req_bus.req_size  = {20'd32, 20'd32};

    // Reset state
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    tick();

    cfg_write(1'b0, 6'd0, 1'b1, 32'h1000, 32'h40, 20'd32, 10'd3);
    cfg_write(1'b1, 6'd0, 1'b0, 32'h2000, 32'h10, 20'd32, 10'd1);
    cfg_write(1'b1, 6'd1, 1'b1, 32'h3000, 32'h08, 20'd32, 10'd1);

    // 1: clean pattern
    do_start();
    chk("t1_busy", busy, 1);
    drive_req(1, 32'h1000, 1, 32'h2000);
    drive_req(1, 32'h1040, 1, 32'h2010);
    drive_req(1, 32'h1080, 1, 32'h3000);
    chk("t1_noerr3", err_valid, 0);
    drive_req(1, 32'h10C0, 1, 32'h3008);
    chk("t1_noerr4", err_valid, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_fail", fail, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_pass_sticky", pass, 1);

    // 2: single address mismatch on the third request
    do_start();
    chk("t2_pass_clr", pass, 0);
    drive_req(1, 32'h1000, 1, 32'h2000);
    drive_req(1, 32'h1040, 1, 32'h2010);
    drive_req(1, 32'h1088, 1, 32'h3000);
    chk("t2_err_valid", err_valid, 1);
    chk("t2_err_ch", err_ch, 0);
    chk("t2_err_code", err_code, 0);
    chk("t2_err_exp", err_exp, 32'h1080);
    chk("t2_err_got", err_got, 32'h1088);
    chk("t2_err_count", err_count, 1);
    drive_req(1, 32'h10C0, 1, 32'h3008);
    chk("t2_resume_ok", err_valid, 0);
    tick();
    chk("t2_done", done, 1);
    chk("t2_fail", fail, 1);
    chk("t2_pass", pass, 0);

    // 3: simultaneous mismatches, then channel 1 alone
    do_start();
    chk("t3_cnt_clr", err_count, 0);
    chk("t3_fail_clr", fail, 0);
    drive_req(1, 32'h1004, 1, 32'h2004);
    chk("t3_both_valid", err_valid, 1);
    chk("t3_both_ch", err_ch, 0);
    chk("t3_both_exp", err_exp, 32'h1000);
    chk("t3_both_got", err_got, 32'h1004);
    chk("t3_both_count", err_count, 2);
    drive_req(1, 32'h1040, 1, 32'h2018);
    chk("t3_ch1_ch", err_ch, 1);
    chk("t3_ch1_exp", err_exp, 32'h2010);
    chk("t3_ch1_count", err_count, 3);
    drive_req(1, 32'h1080, 1, 32'h3000);
    drive_req(1, 32'h10C0, 1, 32'h3008);
    tick();
    chk("t3_done", done, 1);
    chk("t3_fail", fail, 1);

    // 4: overrun after DONE, then stall timeout of 8 cycles
    drive_req(1, 32'h1100, 0, 32'h0);
    chk("t4_ovr_valid", err_valid, 1);
    chk("t4_ovr_code", err_code, 2);
    chk("t4_ovr_ch", err_ch, 0);
    chk("t4_ovr_count", err_count, 4);
    timeout_max = 20'd8;
    do_start();
    repeat (7) tick();
    chk("t4_to_early", err_valid, 0);
    chk("t4_to_busy", busy, 1);
    tick();
    chk("t4_to_valid", err_valid, 1);
    chk("t4_to_code", err_code, 3);
    chk("t4_to_ch", err_ch, 0);
    chk("t4_to_count", err_count, 2);
    chk("t4_to_idle", busy, 0);
    tick();
    chk("t4_to_done", done, 1);
    chk("t4_to_fail", fail, 1);
    timeout_max = '0;

    // 5: asynchronous reset mid-run, then restart mid-run
    do_start();
    drive_req(1, 32'h1000, 1, 32'h2000);
    drive_req(1, 32'h1044, 1, 32'h2010);
    chk("t5_pre_valid", err_valid, 1);
    chk("t5_pre_count", err_count, 1);
    reset = 1'b1;
    #2;
    chk("t5_rst_valid", err_valid, 0);
    chk("t5_rst_count", err_count, 0);
    chk("t5_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    do_start();
    drive_req(1, 32'h1004, 1, 32'h2000);
    chk("t5_run_count", err_count, 1);
    drive_req(1, 32'h1040, 1, 32'h2010);
    do_start();
    chk("t5_restart_count", err_count, 0);
    chk("t5_restart_busy", busy, 1);
    drive_req(1, 32'h1000, 1, 32'h2000);
    chk("t5_entry0", err_valid, 0);
    drive_req(1, 32'h1040, 1, 32'h2010);
    drive_req(1, 32'h1080, 1, 32'h3000);
    drive_req(1, 32'h10C0, 1, 32'h3008);
    chk("t5_clean_count", err_count, 0);
    tick();
    chk("t5_done", done, 1);
    chk("t5_pass", pass, 1);

    // 6: size mismatch, then address+size mismatch; table write while busy
    do_start();
    cfg_write(1'b0, 6'd0, 1'b1, 32'h5000, 32'h40, 20'd32, 10'd3);
    req_bus.req_size = {20'd32, 20'd64};
    drive_req(1, 32'h1000, 1, 32'h2000);
    chk("t6_size_valid", err_valid, SIZE_CHK);
    if (SIZE_CHK) chk("t6_size_code", err_code, 1);
    chk("t6_size_count", err_count, SIZE_CHK ? 1 : 0);
    drive_req(1, 32'h1044, 1, 32'h2010);
    chk("t6_both_code", err_code, 0);
    chk("t6_both_count", err_count, SIZE_CHK ? 2 : 1);
    req_bus.req_size = {20'd32, 20'd32};
    drive_req(1, 32'h1080, 1, 32'h3000);
    drive_req(1, 32'h10C0, 1, 32'h3008);
    tick();
    chk("t6_done", done, 1);

    // 7: the write issued while busy must not have landed
    do_start();
    drive_req(1, 32'h1000, 1, 32'h2000);
    chk("t7_tbl_kept", err_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
